// File: rtl/csc_sync_err_cnt.sv
`default_nettype none
// =============================================================================
// csc_sync_err_cnt : per-group CSC sync-loss event/bad-cycle counters,
//                    first-loss BXN stamps, free-running BXN and sync alarm
// Revision: 1.0
// =============================================================================
module csc_sync_err_cnt #(
  parameter int MXCNT      = 16,
  parameter int MXBXN      = 12,
  parameter int LHC_CYCLE  = 3564,
  parameter int BXN_OFFSET = 0,
  parameter int RECOV_LEN  = 8,
  parameter int ALARM_THR  = 1
) (
  input  logic             clock,
  input  logic             global_reset_n,
  input  logic             ttc_bx0,
  input  logic             ttc_resync,
  input  logic             cnt_clear,
  input  logic             cfebs_synced,
  input  logic             cfebs_lostsync,
  input  logic             cfebs_me1a_synced,
  input  logic             cfebs_me1a_lostsync,
  output logic [MXCNT-1:0] me1b_evt_cnt,
  output logic [MXCNT-1:0] me1b_bad_cnt,
  output logic [MXBXN-1:0] me1b_first_bxn,
  output logic             me1b_first_vld,
  output logic [MXCNT-1:0] me1a_evt_cnt,
  output logic [MXCNT-1:0] me1a_bad_cnt,
  output logic [MXBXN-1:0] me1a_first_bxn,
  output logic             me1a_first_vld,
  output logic [MXBXN-1:0] bxn,
  output logic             sync_err_alarm
);

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_BAD   = 2'd1,
    ST_RECOV = 2'd2
  } state_t;

  localparam logic [MXCNT-1:0] CNT_MAX    = '1;
  localparam logic [MXCNT-1:0] CNT_ONE    = MXCNT'(1);
  localparam logic [MXBXN-1:0] BXN_LAST   = MXBXN'(LHC_CYCLE - 1);
  localparam logic [MXBXN-1:0] BXN_LOAD   = MXBXN'(BXN_OFFSET);
  localparam logic [MXBXN-1:0] BXN_ONE    = MXBXN'(1);
  localparam logic [8:0]       RECOV_EXIT = 9'(RECOV_LEN);

  logic             clr;
  logic [1:0]       grp_synced;
  logic [1:0][MXCNT-1:0] evt_cnt;
  logic [1:0][MXCNT-1:0] bad_cnt;
  logic [1:0][MXBXN-1:0] first_bxn;
  logic [1:0]            first_vld;

  logic [MXBXN-1:0] bxn_q, bxn_d;
  logic             alarm_q, alarm_d;
  logic             cnt_term;

  assign clr        = cnt_clear | ttc_resync;
  assign grp_synced = {cfebs_me1a_synced, cfebs_synced};

  always_comb begin
    bxn_d = bxn_q + BXN_ONE;
    if (ttc_bx0)               bxn_d = BXN_LOAD;
    else if (bxn_q == BXN_LAST) bxn_d = '0;
  end

  // Group 0 is ME1b, group 1 is ME1a.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_grp
      state_t           state_q, state_d;
      logic [7:0]       rcnt_q, rcnt_d;
      logic [8:0]       rcnt_inc;
      logic [MXCNT-1:0] evt_q, evt_d, bad_q, bad_d;
      logic [MXBXN-1:0] fbxn_q, fbxn_d;
      logic             fvld_q, fvld_d;
      logic             synced;

      assign synced = grp_synced[g];

      always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        evt_d    = evt_q;
        bad_d    = bad_q;
        fbxn_d   = fbxn_q;
        fvld_d   = fvld_q;
        rcnt_inc = {1'b0, rcnt_q} + 9'd1;
        // A clear wins over anything sampled in the same cycle.
        if (clr) begin
          state_d = ST_OK;
          rcnt_d  = '0;
          evt_d   = '0;
          bad_d   = '0;
          fbxn_d  = '0;
          fvld_d  = 1'b0;
        end else begin
          if (!synced && bad_q != CNT_MAX) bad_d = bad_q + CNT_ONE;
          case (state_q)
            ST_OK: begin
              if (!synced) begin
                state_d = ST_BAD;
                if (evt_q != CNT_MAX) evt_d = evt_q + CNT_ONE;
                if (!fvld_q) begin
                  fbxn_d = bxn_q;
                  fvld_d = 1'b1;
                end
              end
            end
            ST_BAD: begin
              if (synced) begin
                state_d = ST_RECOV;
                rcnt_d  = 8'd1;
              end
            end
            ST_RECOV: begin
              if (!synced) begin
                state_d = ST_BAD;
                rcnt_d  = '0;
              end else if (rcnt_inc >= RECOV_EXIT) begin
                state_d = ST_OK;
                rcnt_d  = '0;
              end else begin
                rcnt_d  = rcnt_inc[7:0];
              end
            end
            default: begin
              state_d = ST_OK;
              rcnt_d  = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clock) begin
        if (!global_reset_n) begin
          state_q <= ST_OK;
          rcnt_q  <= '0;
          evt_q   <= '0;
          bad_q   <= '0;
          fbxn_q  <= '0;
          fvld_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
          evt_q   <= evt_d;
          bad_q   <= bad_d;
          fbxn_q  <= fbxn_d;
          fvld_q  <= fvld_d;
        end
      end

      assign evt_cnt[g]   = evt_q;
      assign bad_cnt[g]   = bad_q;
      assign first_bxn[g] = fbxn_q;
      assign first_vld[g] = fvld_q;
    end

    if (ALARM_THR == 0) begin : g_thr_off
      assign cnt_term = 1'b0;
    end else begin : g_thr_on
      localparam logic [MXCNT-1:0] THR = MXCNT'(ALARM_THR);
      assign cnt_term = (evt_cnt[0] >= THR) | (evt_cnt[1] >= THR);
    end
  endgenerate

  // Count term looks at the already-registered counters, giving one cycle of lag.
  assign alarm_d = cfebs_lostsync | cfebs_me1a_lostsync | cnt_term;

  always_ff @(posedge clock) begin
    if (!global_reset_n) begin
      bxn_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      bxn_q   <= bxn_d;
      alarm_q <= alarm_d;
    end
  end

  assign me1b_evt_cnt   = evt_cnt[0];
  assign me1b_bad_cnt   = bad_cnt[0];
  assign me1b_first_bxn = first_bxn[0];
  assign me1b_first_vld = first_vld[0];
  assign me1a_evt_cnt   = evt_cnt[1];
  assign me1a_bad_cnt   = bad_cnt[1];
  assign me1a_first_bxn = first_bxn[1];
  assign me1a_first_vld = first_vld[1];
  assign bxn            = bxn_q;
  assign sync_err_alarm = alarm_q;

endmodule
`default_nettype wire

// File: doc/csc_sync_err_cnt.md
Name: csc_sync_err_cnt

Overview:
- Sits directly downstream of the CSC fiber sync monitor; consumes its per-group (ME1b = CFEB0-3, ME1a = CFEB4-6) synced/lostsync flags.
- Per group: counts loss-of-sync events and bad-sync cycles, and time-stamps the BXN of the first loss since the last clear.
- Raises a single registered alarm for the VME status/interrupt logic.
- Counters are read by VME and cleared by a VME pulse or a TTC resync.

Parameters:
- MXCNT, 16, width of event and bad-cycle counters (saturating).
- MXBXN, 12, width of BXN counter and time stamps.
- LHC_CYCLE, 3564, BXN wrap value (counter counts 0..LHC_CYCLE-1).
- BXN_OFFSET, 0, value loaded into BXN counter on ttc_bx0.
- RECOV_LEN, 8, consecutive good cycles required to leave RECOV (range 1..255).
- ALARM_THR, 1, event count (either group) at or above which the alarm asserts.

Ports:
- clock  in  1  40 MHz LHC clock; all logic on posedge.
- global_reset_n  in  1  synchronous, active-low reset.
- ttc_bx0  in  1  BX0 strobe; reloads BXN counter.
- ttc_resync  in  1  clears counters, stamps and FSMs (same as cnt_clear).
- cnt_clear  in  1  VME clear pulse.
- cfebs_synced  in  1  ME1b group in sync this cycle.
- cfebs_lostsync  in  1  ME1b sticky lost-sync from monitor.
- cfebs_me1a_synced  in  1  ME1a group in sync this cycle.
- cfebs_me1a_lostsync  in  1  ME1a sticky lost-sync from monitor.
- me1b_evt_cnt  out  MXCNT  ME1b loss events.
- me1b_bad_cnt  out  MXCNT  ME1b cycles with synced=0.
- me1b_first_bxn  out  MXBXN  BXN of first ME1b event.
- me1b_first_vld  out  1  me1b_first_bxn valid.
- me1a_evt_cnt  out  MXCNT  ME1a loss events.
- me1a_bad_cnt  out  MXCNT  ME1a cycles with synced=0.
- me1a_first_bxn  out  MXBXN  BXN of first ME1a event.
- me1a_first_vld  out  1  me1a_first_bxn valid.
- bxn  out  MXBXN  free-running BXN counter.
- sync_err_alarm  out  1  registered alarm.

Behaviour:
- Reset (global_reset_n=0 at posedge): all outputs 0, bxn=0, both FSMs in OK, recovery counters 0.
- BXN counter:
  - Increments each cycle and wraps LHC_CYCLE-1 -> 0.
  - ttc_bx0 loads BXN_OFFSET; this overrides the increment.
- Clear (cnt_clear | ttc_resync):
  - Next cycle: evt/bad counters 0, first_vld 0, first_bxn 0, FSMs to OK.
  - bxn is not affected.
  - A clear takes priority over any event or bad cycle sampled in the same cycle; that event is dropped.
- Per-group FSM, identical instance for each group; inputs s = synced, l = lostsync:
  - OK: s=0 -> BAD. This is one event: evt_cnt+1; if first_vld=0, first_bxn<=bxn and first_vld<=1.
  - BAD: s=1 -> RECOV with recovery counter=1; s=0 stays in BAD.
  - RECOV: s=0 -> BAD, not a new event. s=1 increments the recovery counter; when the counter reaches RECOV_LEN -> OK.
  - RECOV_LEN=1 means a single good cycle in BAD returns to OK via RECOV on the next good cycle. Implementer: exit RECOV when the counter is >= RECOV_LEN after the increment.
- bad_cnt increments on every sampled cycle with s=0, in any state.
- Counters saturate at all-ones and never wrap. first_bxn is held until a clear.
- Latency: input sampled at edge N -> counters, first_bxn and first_vld update at edge N.
- sync_err_alarm registered at edge N+1. It is the OR of:
  - cfebs_lostsync or cfebs_me1a_lostsync;
  - me1b_evt_cnt >= ALARM_THR;
  - me1a_evt_cnt >= ALARM_THR.
- ALARM_THR=0 disables the count term only. Alarm clears one cycle after the clear takes effect, provided the lostsync inputs are 0.
- Simultaneous events in both groups are counted independently, with the same bxn stamp.
- Reset mid-burst: counters 0 and FSM OK. If synced is still 0 after reset release, a new event is counted on the first cycle sampled with reset deasserted.

Test Plan:
- Reset, both synced=1 for 5000 cycles, bx0 at cycle 100 -> all counters 0, alarm 0; bxn wraps at 3563 -> 0, and equals (cycle-100) mod 3564 after bx0.
- ME1b synced=0 for 3 cycles at bxn=200, then 1 -> me1b_evt_cnt=1, me1b_bad_cnt=3, first_bxn=200, first_vld=1, alarm=1 one cycle later; ME1a counts stay 0.
- ME1b pattern 0,1,1,0,1x8 (RECOV_LEN=8) -> evt_cnt=1, bad_cnt=2; FSM back to OK; a following 0 gives evt_cnt=2 while first_bxn stays unchanged.
- Hold ME1a synced=0 for 70000 cycles -> me1a_bad_cnt saturates at 65535, me1a_evt_cnt=1.
- Assert cnt_clear in the same cycle as an OK->BAD transition -> counters 0, first_vld 0 next cycle; the event is not counted. ttc_resync behaves identically.
- Both groups drop sync at the same cycle with bxn=3563 -> both first_bxn=3563, both evt_cnt=1. Pull global_reset_n low for 1 cycle mid-burst -> all outputs 0 next cycle, then evt_cnt=1 again.
